// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes, oversampling ratio.
// Imported by the receiver and its helper blocks.
package uart_pkg;

    localparam int OVERSAMPLE = 4;

    // Tick counter values: mid-start-bit check and last tick of a bit period.
    localparam logic [1:0] TCNT_MID  = 2'(OVERSAMPLE / 2 - 1);
    localparam logic [1:0] TCNT_LAST = 2'(OVERSAMPLE - 1);

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    // Code 2'b11 is reserved and behaves like PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_os4_if.sv
// Receive-byte holding register handshake: data plus valid/ready.
// master = receiver, slave = consuming peripheral bus logic.
interface uart_rx_os4_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous serial line; resets to idle-high.
// Latency SYNC_STAGES clk; no backpressure.
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) chain <= '1;
        else       chain <= {chain[SYNC_STAGES-2:0], d};
    end

    assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_os4.sv
// 4x-oversampled 8N1/8E1/8O1 UART receiver with a one-byte valid/ready holding register.
// Byte appears 1 clk after the stop-bit tick; a byte arriving while the register is full is dropped as overrun.
module uart_rx_os4
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 baudtick,
    input  logic                 rxd,
    input  logic [1:0]           parity_mode,
    input  logic                 clr_err,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun,
    output logic                 rx_busy,
    uart_rx_os4_if.master        rx
);
    localparam int BW = $clog2(DATA_W + 1);

    logic              rxd_s;
    uart_state_t       state;
    logic [1:0]        tcnt;
    logic [BW-1:0]     bitcnt;
    logic [DATA_W-1:0] shreg;
    logic [1:0]        mode_q;
    logic              par_bad;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rxd),
        .q    (rxd_s)
    );

    logic stop_tick, stop_ok, stop_bad_par, stop_low;
    assign stop_tick    = baudtick && (state == ST_STOP) && (tcnt == TCNT_LAST);
    assign stop_low     = stop_tick && !rxd_s;
    assign stop_bad_par = stop_tick && rxd_s && par_bad;
    assign stop_ok      = stop_tick && rxd_s && !par_bad;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            tcnt    <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            mode_q  <= PAR_NONE;
            par_bad <= 1'b0;
        end else begin
            if (state == ST_IDLE) mode_q <= parity_mode;
            if (baudtick) begin
                unique case (state)
                    ST_IDLE: begin
                        if (!rxd_s) begin
                            state <= ST_START;
                            tcnt  <= '0;
                        end
                    end
                    ST_START: begin
                        if (tcnt == TCNT_MID) begin
                            if (rxd_s) begin
                                state <= ST_IDLE;
                            end else begin
                                state   <= ST_DATA;
                                tcnt    <= '0;
                                bitcnt  <= '0;
                                par_bad <= 1'b0;
                            end
                        end else begin
                            tcnt <= tcnt + 2'd1;
                        end
                    end
                    // The 2-bit counter wraps to 0 on the sampling tick by itself.
                    ST_DATA: begin
                        tcnt <= tcnt + 2'd1;
                        if (tcnt == TCNT_LAST) begin
                            shreg  <= {rxd_s, shreg[DATA_W-1:1]};
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt == BW'(DATA_W - 1))
                                state <= parity_enabled(mode_q) ? ST_PARITY : ST_STOP;
                        end
                    end
                    ST_PARITY: begin
                        tcnt <= tcnt + 2'd1;
                        if (tcnt == TCNT_LAST) begin
                            par_bad <= ((^shreg) ^ rxd_s) != (mode_q == PAR_ODD);
                            state   <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        tcnt <= tcnt + 2'd1;
                        if (tcnt == TCNT_LAST) state <= rxd_s ? ST_IDLE : ST_BREAK;
                    end
                    ST_BREAK: begin
                        if (rxd_s) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Holding register and sticky flags; a set in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (valid_q && rx.rx_ready) valid_q <= 1'b0;
            if (stop_ok && (!valid_q || rx.rx_ready)) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end
            if (clr_err) begin
                err_frame   <= 1'b0;
                err_parity  <= 1'b0;
                err_overrun <= 1'b0;
            end
            if (stop_low)                             err_frame   <= 1'b1;
            if (stop_bad_par)                         err_parity  <= 1'b1;
            if (stop_ok && valid_q && !rx.rx_ready)   err_overrun <= 1'b1;
        end
    end

    assign rx.rx_data  = data_q;
    assign rx.rx_valid = valid_q;
    assign rx_busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_os4.sv
// Bench for uart_rx_os4: directed frames plus random frames against a frame-level outcome model.
module tb_uart_rx_os4;
    localparam int CLKS_PER_BIT = 432;
    localparam int TICK_DIV     = 108;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       baudtick = 1'b0;
    logic       rxd = 1'b1;
    logic [1:0] parity_mode = 2'b00;
    logic       clr_err = 1'b0;
    logic       err_frame, err_parity, err_overrun, rx_busy;

    uart_rx_os4_if #(.DATA_W(8)) bus ();

    uart_rx_os4 #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .baudtick    (baudtick),
        .rxd         (rxd),
        .parity_mode (parity_mode),
        .clr_err     (clr_err),
        .err_frame   (err_frame),
        .err_parity  (err_parity),
        .err_overrun (err_overrun),
        .rx_busy     (rx_busy),
        .rx          (bus)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            baudtick = 1'b1;
            @(negedge clk);
            baudtick = 1'b0;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    // Expected externally visible state, updated per whole frame.
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_fe = 1'b0, exp_pe = 1'b0, exp_ov = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_busy);
        check({tag, ".valid"},   32'(bus.rx_valid), 32'(exp_valid));
        if (exp_valid) check({tag, ".data"}, 32'(bus.rx_data), 32'(exp_data));
        check({tag, ".frame"},   32'(err_frame),    32'(exp_fe));
        check({tag, ".parity"},  32'(err_parity),   32'(exp_pe));
        check({tag, ".overrun"}, 32'(err_overrun),  32'(exp_ov));
        check({tag, ".busy"},    32'(rx_busy),      32'(exp_busy));
    endtask

    // Frame outcome from the line rules: stop error beats parity error beats delivery.
    task automatic model_frame(input logic [7:0] d, input logic [1:0] mode, input logic pbit, input logic stop);
        int  ones;
        bit  par_on;
        par_on = (mode == 2'b01) || (mode == 2'b10);
        ones   = $countones(d) + int'(pbit);
        if (!stop)                                          exp_fe = 1'b1;
        else if (par_on && ((ones % 2) != (mode == 2'b10 ? 1 : 0))) exp_pe = 1'b1;
        else if (exp_valid)                                 exp_ov = 1'b1;
        else begin
            exp_valid = 1'b1;
            exp_data  = d;
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CLKS_PER_BIT) @(negedge clk);
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input logic pbit, input logic stop);
        logic prev_valid;
        prev_valid = exp_valid;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                rxd = d[i];
                repeat (CLKS_PER_BIT / 2) @(negedge clk);
                check({tag, ".mid_busy"},  32'(rx_busy),      32'd1);
                check({tag, ".mid_valid"}, 32'(bus.rx_valid), 32'(prev_valid));
                repeat (CLKS_PER_BIT - CLKS_PER_BIT / 2) @(negedge clk);
            end else begin
                send_bit(d[i]);
            end
        end
        if (parity_mode == 2'b01 || parity_mode == 2'b10) send_bit(pbit);
        send_bit(stop);
        model_frame(d, parity_mode, pbit, stop);
        check_all({tag, ".end"}, !stop);
    endtask

    task automatic idle_gap(input string tag, input int nbits);
        rxd = 1'b1;
        repeat (nbits * CLKS_PER_BIT) @(negedge clk);
        check_all({tag, ".gap"}, 1'b0);
    endtask

    task automatic consume(input string tag);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        exp_valid = 1'b0;
        check({tag, ".consumed"}, 32'(bus.rx_valid), 32'd0);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_fe = 1'b0;
        exp_pe = 1'b0;
        exp_ov = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic [1:0] rmode;
        logic       rp, rstop;

        bus.rx_ready = 1'b0;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.data", 32'(bus.rx_data), 32'd0);
        check_all("reset", 1'b0);
        rstn = 1'b1;
        repeat (CLKS_PER_BIT) @(negedge clk);

        // 0x55, no parity, then handshake.
        parity_mode = 2'b00;
        frame("b55", 8'h55, 1'b0, 1'b1);
        consume("b55");
        idle_gap("b55", 1);

        // Short low glitch on the start bit.
        rxd = 1'b0;
        repeat (140) @(negedge clk);
        check("glitch.busy", 32'(rx_busy), 32'd1);
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (400) @(negedge clk);
        check_all("glitch", 1'b0);

        // Even parity: wrong then right parity bit.
        parity_mode = 2'b01;
        idle_gap("pa_setup", 1);
        frame("a5_bad", 8'hA5, 1'b1, 1'b1);
        idle_gap("a5_bad", 1);
        frame("a5_ok", 8'hA5, 1'b0, 1'b1);
        consume("a5_ok");
        idle_gap("a5_ok", 1);

        // Framing error with the line held low, then recovery.
        parity_mode = 2'b00;
        idle_gap("fe_setup", 1);
        frame("b3c", 8'h3C, 1'b0, 1'b0);
        repeat (3 * CLKS_PER_BIT) @(negedge clk);
        check_all("break_hold", 1'b1);
        idle_gap("break_rel", 1);
        frame("b81", 8'h81, 1'b0, 1'b1);
        consume("b81");
        idle_gap("b81", 1);

        // Overrun on back-to-back bytes, then clear flags.
        frame("b12", 8'h12, 1'b0, 1'b1);
        frame("b34", 8'h34, 1'b0, 1'b1);
        rxd = 1'b1;
        pulse_clr();
        check_all("clr", 1'b0);

        // Reset in data bit 4 with a byte still pending.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'hF0 >> i));
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        rstn = 1'b0;
        #1;
        exp_valid = 1'b0; exp_data = 8'h00;
        exp_fe = 1'b0; exp_pe = 1'b0; exp_ov = 1'b0;
        check("rst_mid.data", 32'(bus.rx_data), 32'd0);
        check_all("rst_mid", 1'b0);
        rxd = 1'b1;
        repeat (CLKS_PER_BIT) @(negedge clk);
        rstn = 1'b1;
        idle_gap("rst_rel", 1);
        frame("b0f", 8'h0F, 1'b0, 1'b1);
        consume("b0f");
        idle_gap("b0f", 1);

        // Random frames: mode, data, parity correctness, stop bit, consumption, clears.
        for (int n = 0; n < 5; n++) begin
            rmode = 2'($urandom_range(0, 3));
            parity_mode = rmode;
            rd = 8'($urandom);
            rp = (^rd) ^ (rmode == 2'b10);
            if ($urandom_range(0, 3) == 0) rp = ~rp;
            rstop = ($urandom_range(0, 3) != 0);
            frame("rnd", rd, rp, rstop);
            idle_gap("rnd", 1);
            if ($urandom_range(0, 1) == 1) consume("rnd");
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                check_all("rnd_clr", 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
